adc_s2mm_packer: RTL and testbench

ADC_S2MM_PACKER -- requirements
Module: adc_s2mm_packer

---
 rtl/adc_pkg.sv | 9 +
 rtl/sync_fifo.sv | 75 +++++++
 rtl/adc_s2mm_packer.sv | 72 +++++++
 tb/tb_adc_s2mm_packer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// adc_pkg: shared FSM states, widths and sample packing for the ADC S2MM packer
package adc_pkg;
    localparam int SAMPLE_W = 12;
    localparam int BEAT_W = 32;
    typedef enum logic [1:0] {IDLE, RUN, FINISH, DRAIN} state_t;
    function automatic logic [BEAT_W-1:0] pack_iq(input logic [SAMPLE_W-1:0] i, input logic [SAMPLE_W-1:0] q);
        return {{(16-SAMPLE_W){q[SAMPLE_W-1]}}, q, {(16-SAMPLE_W){i[SAMPLE_W-1]}}, i};
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with a registered output stage; total capacity DEPTH including the output register
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic out_vld_q, out_vld_d;
    logic wr, pop, load, mem_empty, bypass;
    assign full = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign rd_valid = out_vld_q;
    assign rd_data = out_q;
    // Refill the output register from memory, or straight from the input when memory is empty
    always_comb begin
        wr = wr_en && !full;
        pop = out_vld_q && rd_ready;
        load = !out_vld_q || pop;
        mem_empty = (cnt_q - (AW+1)'(out_vld_q)) == '0;
        bypass = load && mem_empty && wr;
        mem_d = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d = out_q;
        out_vld_d = out_vld_q;
        if (wr && !bypass) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (load) begin
            out_vld_d = !mem_empty || wr;
            if (!mem_empty) begin
                out_d = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
            end else if (wr) begin
                out_d = wr_data;
            end
        end
        cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    end
    // Pointers, occupancy and output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            out_vld_q <= out_vld_d;
        end
    end
    // Storage array, contents need no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/adc_s2mm_packer.sv
// adc_s2mm_packer: packs AD9361 I/Q samples into fixed-length AXI-Stream packets for an S2MM DMA
module adc_s2mm_packer
    import adc_pkg::*;
#(
    parameter int PKT_LEN = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_valid,
    input  logic [11:0] adc_i,
    input  logic [11:0] adc_q,
    output logic [31:0] m_axis_tdata,
    output logic [3:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] overflow_cnt,
    output logic        busy
);
    localparam int CW = $clog2(PKT_LEN);
    state_t state_q, state_d;
    logic [CW-1:0] beat_q, beat_d;
    logic [15:0] ovf_q, ovf_d;
    logic window, wr, drop, last, fifo_full, fifo_empty;
    assign m_axis_tkeep = 4'hF;
    assign overflow_cnt = ovf_q;
    assign busy = state_q != IDLE;
    // Accept/drop decision, beat counter and saturating overflow count
    always_comb begin
        window = state_q == RUN || (state_q == FINISH && beat_q != '0);
        wr = window && adc_valid && !fifo_full;
        drop = window && adc_valid && fifo_full;
        last = beat_q == CW'(PKT_LEN - 1);
        beat_d = wr ? (last ? '0 : beat_q + 1'b1) : beat_q;
        ovf_d = (drop && ovf_q != 16'hFFFF) ? ovf_q + 16'd1 : ovf_q;
    end
    // Next state: FINISH pads out the open packet, DRAIN empties the buffer
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable ? RUN : IDLE;
            RUN:     state_d = enable ? RUN : FINISH;
            FINISH:  state_d = (beat_q == '0 || (wr && last)) ? DRAIN : FINISH;
            default: state_d = fifo_empty ? IDLE : DRAIN;
        endcase
    end
    // State, beat counter and overflow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q <= '0;
            ovf_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            ovf_q <= ovf_d;
        end
    end
    sync_fifo #(.WIDTH(BEAT_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr),
        .wr_data  ({last, pack_iq(adc_i, adc_q)}),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_ready (m_axis_tready),
        .rd_valid (m_axis_tvalid),
        .rd_data  ({m_axis_tlast, m_axis_tdata})
    );
endmodule

// File: tb/tb_adc_s2mm_packer.sv
// tb_adc_s2mm_packer: scoreboard bench for the ADC S2MM packer with PKT_LEN=4, FIFO_DEPTH=16
module tb_adc_s2mm_packer;
    typedef struct {
        logic [11:0] i;
        logic [11:0] q;
        logic [31:0] exp;
    } vec_t;
    logic clk = 0, rst = 1, enable = 0, adc_valid = 0, tready = 0;
    logic [11:0] adc_i = 0, adc_q = 0;
    logic [31:0] tdata;
    logic [3:0] tkeep;
    logic tlast, tvalid, busy;
    logic [15:0] ovf;
    int total = 0, bad = 0, beats = 0, nbeat = 0;
    logic [32:0] sb[$];
    logic stall = 0;
    logic [32:0] held = 0;
    vec_t tbl[8];

    adc_s2mm_packer #(.PKT_LEN(4), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .adc_valid(adc_valid),
        .adc_i(adc_i), .adc_q(adc_q), .m_axis_tdata(tdata), .m_axis_tkeep(tkeep),
        .m_axis_tlast(tlast), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .overflow_cnt(ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [11:0] i, input logic [11:0] q);
        return {{4{q[11]}}, q, {4{i[11]}}, i};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d);
        sb.push_back({nbeat == 3, d});
        nbeat = (nbeat + 1) % 4;
    endtask

    task automatic send(input logic [11:0] i, input logic [11:0] q, input bit p);
        adc_i = i;
        adc_q = q;
        adc_valid = 1;
        if (p) push(pk(i, q));
        @(posedge clk) #1;
        adc_valid = 0;
    endtask

    task automatic start_run();
        enable = 1;
        @(posedge clk) #1;
        chk("busy_run", 32'(busy), 1);
    endtask

    task automatic finish_wait(input int exp_beats);
        int n = 0;
        enable = 0;
        adc_valid = 0;
        tready = 1;
        while (busy && n < 300) begin
            @(posedge clk) #1;
            n++;
        end
        chk("busy_idle", 32'(busy), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        chk("beat_count", 32'(beats), 32'(exp_beats));
    endtask

    // Output monitor: scoreboard compare on handshakes and hold-stability under backpressure
    always @(negedge clk) begin
        if (rst) begin
            stall = 0;
        end else begin
            if (stall) begin
                chk("hold_valid", 32'(tvalid), 1);
                chk("hold_data", tdata, held[31:0]);
                chk("hold_last", 32'(tlast), 32'(held[32]));
            end
            if (tvalid && tready) begin
                beats++;
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got %h want no beat", tdata);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    chk("beat_data", tdata, e[31:0]);
                    chk("beat_last", 32'(tlast), 32'(e[32]));
                end
            end
            stall = tvalid && !tready;
            held = {tlast, tdata};
        end
    end

    initial begin
        tbl[0] = '{12'h800, 12'h7FF, 32'h07FF_F800};
        tbl[1] = '{12'h7FF, 12'h800, 32'hF800_07FF};
        tbl[2] = '{12'h000, 12'hFFF, 32'hFFFF_0000};
        tbl[3] = '{12'h001, 12'h123, 32'h0123_0001};
        tbl[4] = '{12'hABC, 12'h555, 32'h0555_FABC};
        tbl[5] = '{12'hFFF, 12'h000, 32'h0000_FFFF};
        tbl[6] = '{12'h7F0, 12'h8F0, 32'hF8F0_07F0};
        tbl[7] = '{12'h3A5, 12'hC3A, 32'hFC3A_03A5};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("tkeep", 32'(tkeep), 32'hF);
        rst = 0;
        @(posedge clk) #1;
        chk("idle_busy", 32'(busy), 0);

        // Table-driven packing, two full packets at full rate
        tready = 1;
        start_run();
        for (int k = 0; k < 8; k++) begin
            adc_i = tbl[k].i;
            adc_q = tbl[k].q;
            adc_valid = 1;
            sb.push_back({k % 4 == 3, tbl[k].exp});
            nbeat = (nbeat + 1) % 4;
            @(posedge clk) #1;
            if (k == 0) chk("latency1_valid", 32'(tvalid), 1);
        end
        adc_valid = 0;
        finish_wait(8);

        // Enable dropped mid-packet: FINISH pads to 8 beats, DRAIN ignores samples
        beats = 0;
        start_run();
        for (int k = 0; k < 6; k++) send(12'(k * 17), 12'(k * 29 + 3), 1);
        enable = 0;
        send(12'h111, 12'h222, 1);
        send(12'h333, 12'h444, 1);
        send(12'h555, 12'h666, 0);
        send(12'h777, 12'h888, 0);
        finish_wait(8);
        chk("drain_no_ovf", 32'(ovf), 0);

        // Backpressure for 40 cycles: 16 stored, 24 dropped
        beats = 0;
        tready = 0;
        start_run();
        for (int k = 0; k < 40; k++) send(12'(k * 37), 12'(k * 91 + 5), k < 16);
        chk("ovf_24", 32'(ovf), 24);
        chk("stall_valid", 32'(tvalid), 1);
        chk("stall_head", tdata, pk(12'd0, 12'd5));
        finish_wait(16);
        chk("ovf_kept", 32'(ovf), 24);

        // Reset at beat 2 of a packet
        beats = 0;
        tready = 1;
        start_run();
        send(12'h0A1, 12'h0B1, 1);
        send(12'h0A2, 12'h0B2, 1);
        adc_i = 12'h0A3;
        adc_q = 12'h0B3;
        adc_valid = 1;
        rst = 1;
        @(posedge clk) #1;
        adc_valid = 0;
        chk("mid_rst_tvalid", 32'(tvalid), 0);
        chk("mid_rst_ovf", 32'(ovf), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        sb.delete();
        nbeat = 0;
        rst = 0;
        @(posedge clk) #1;
        chk("post_rst_busy", 32'(busy), 1);
        beats = 0;
        for (int k = 0; k < 4; k++) send(12'(k + 100), 12'(k + 200), 1);
        finish_wait(4);

        // Random backpressure with sparse samples, 60 samples = 15 whole packets
        beats = 0;
        start_run();
        begin
            int sent = 0;
            for (int c = 0; c < 3000 && sent < 60; c++) begin
                tready = 1'($urandom_range(0, 1));
                if (sb.size() < 8 && $urandom_range(0, 2) != 0) begin
                    adc_i = 12'($urandom);
                    adc_q = 12'($urandom);
                    adc_valid = 1;
                    push(pk(adc_i, adc_q));
                    sent++;
                end else begin
                    adc_valid = 0;
                end
                @(posedge clk) #1;
            end
            adc_valid = 0;
            chk("rand_sent", 32'(sent), 60);
        end
        enable = 0;
        for (int c = 0; c < 20; c++) begin
            tready = 1'($urandom_range(0, 1));
            @(posedge clk) #1;
        end
        finish_wait(60);
        chk("rand_ovf", 32'(ovf), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
